// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: expands one start command into the per-cycle 35-bit core inst bundle (registered outputs, no extra lag).
// DRAIN stalls on ofifo_valid; defining SEQ_WDOG_EN bounds that stall with a watchdog that raises err and ends the job.
module core_inst_sequencer #(
   parameter int row        = 8,
   parameter int col        = 8,
   parameter int addr_width = 11,
   parameter int cnt_width  = 11,
   parameter int WDOG_CYC   = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_width-1:0] w_base,
   input  logic [addr_width-1:0] x_base,
   input  logic [addr_width-1:0] p_base,
   input  logic [cnt_width-1:0]  n_act,
   input  logic                  ofifo_valid,
   output logic [34:0]           inst,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {
      S_IDLE, S_WFETCH, S_KLOAD, S_KGAP, S_XFETCH, S_EXEC, S_DRAIN, S_DONE
   } state_t;

   localparam logic [34:0]          IDLE_WORD = 35'h1_800C_0000;
   localparam logic [cnt_width-1:0] ROW_C     = cnt_width'(row);
   localparam logic [cnt_width-1:0] ROW_M1    = cnt_width'(row - 1);
   localparam logic [cnt_width-1:0] COL_M1    = cnt_width'(col - 1);

   // The inst map has fixed 11-bit address fields.
   if (addr_width != 11 || row < 1 || col < 1 || WDOG_CYC < 2) begin : g_param_chk
      $error("core_inst_sequencer: unsupported parameter set");
   end

   state_t                state_q, state_nxt;
   logic [cnt_width-1:0]  cnt_q, cnt_nxt;
   logic [addr_width-1:0] wb_q, xb_q, pb_q, wb_nxt, xb_nxt, pb_nxt;
   logic [cnt_width-1:0]  na_q, na_nxt;
   logic [cnt_width-1:0]  rd_cnt_q, wr_cnt_q;
   logic                  start_ok, rd_fire, wr_fire, wdog_trip;
   logic [34:0]           inst_nxt;

`ifdef SEQ_WDOG_EN
   localparam int WDW = $clog2(WDOG_CYC + 1);
   logic [WDW-1:0] wdog_q;

   assign wdog_trip = (state_q == S_DRAIN) && !ofifo_valid && (wdog_q == WDW'(WDOG_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wdog_q <= '0;
      else if (state_q != S_DRAIN || ofifo_valid)
         wdog_q <= '0;
      else
         wdog_q <= wdog_q + 1'b1;
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_comb begin
      state_nxt = state_q;
      start_ok  = 1'b0;
      wb_nxt    = wb_q;
      xb_nxt    = xb_q;
      pb_nxt    = pb_q;
      na_nxt    = na_q;
      case (state_q)
         S_IDLE: if (start) begin
            start_ok  = 1'b1;
            wb_nxt    = w_base;
            xb_nxt    = x_base;
            pb_nxt    = p_base;
            na_nxt    = n_act;
            state_nxt = (n_act != '0) ? S_WFETCH : S_DONE;
         end
         S_WFETCH: if (cnt_q == ROW_C)         state_nxt = S_KLOAD;
         S_KLOAD:  if (cnt_q == COL_M1)        state_nxt = S_KGAP;
         S_KGAP:   if (cnt_q == ROW_M1)        state_nxt = S_XFETCH;
         S_XFETCH: if (cnt_q == na_q)          state_nxt = S_EXEC;
         S_EXEC:   if (cnt_q == na_q - 1'b1)   state_nxt = S_DRAIN;
         // inst[32] low means the final pmem write is on the bus this cycle.
         S_DRAIN:  if (wdog_trip || (!inst[32] && wr_cnt_q == na_q)) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase

      cnt_nxt = (state_nxt != state_q) ? '0 : cnt_q + 1'b1;
      rd_fire = (state_q == S_DRAIN) && (state_nxt == S_DRAIN) && ofifo_valid && (rd_cnt_q != na_q);
      wr_fire = (state_q == S_DRAIN) && inst[6];

      // Outputs are computed for the state being entered so they line up with it.
      inst_nxt = IDLE_WORD;
      case (state_nxt)
         S_WFETCH: begin
            if (cnt_nxt < ROW_C) begin
               inst_nxt[19]   = 1'b0;
               inst_nxt[17:7] = wb_nxt + addr_width'(cnt_nxt);
            end
            inst_nxt[2] = (cnt_nxt != '0);
         end
         S_KLOAD: begin
            inst_nxt[3] = 1'b1;
            inst_nxt[0] = 1'b1;
         end
         S_XFETCH: begin
            if (cnt_nxt != na_q) begin
               inst_nxt[19]   = 1'b0;
               inst_nxt[17:7] = xb_q + addr_width'(cnt_nxt);
            end
            inst_nxt[2] = (cnt_nxt != '0);
         end
         S_EXEC: begin
            inst_nxt[3] = 1'b1;
            inst_nxt[1] = 1'b1;
         end
         default: ;
      endcase
      if (rd_fire)
         inst_nxt[6] = 1'b1;
      if (wr_fire) begin
         inst_nxt[32]    = 1'b0;
         inst_nxt[31]    = 1'b0;
         inst_nxt[30:20] = pb_q + addr_width'(wr_cnt_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wb_q     <= '0;
         xb_q     <= '0;
         pb_q     <= '0;
         na_q     <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         inst     <= IDLE_WORD;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         wb_q     <= wb_nxt;
         xb_q     <= xb_nxt;
         pb_q     <= pb_nxt;
         na_q     <= na_nxt;
         rd_cnt_q <= start_ok ? '0 : rd_cnt_q + cnt_width'(rd_fire);
         wr_cnt_q <= start_ok ? '0 : wr_cnt_q + cnt_width'(wr_fire);
         inst     <= inst_nxt;
         busy     <= (state_nxt != S_IDLE);
         done     <= (state_nxt == S_DONE);
         err      <= start_ok ? 1'b0 : (err | wdog_trip);
      end
   end

endmodule
